// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
// ------------------
// Groups the two buses of the fetch sequencer: the byte-wide program-memory
// read port and the instruction/redirect port toward the core.
//
// Handshake: the instruction is transferred on every rising edge where
// instr_valid and instr_ready are both 1. Once instr_valid is raised it stays
// high, with instr/instr_pc/instr_err stable, until that transfer or a
// redirect. instr_ready may be held high permanently.
//
// Signals
//   mem_re       sequencer -> memory  byte read strobe
//   mem_addr     sequencer -> memory  byte address for mem_re
//   mem_rdata    memory -> sequencer  read data, valid one cycle after mem_re
//   redirect     core -> sequencer    load redirect_pc, abandon current fetch
//   redirect_pc  core -> sequencer    new fetch byte address
//   instr_valid  sequencer -> core    instr/instr_pc/instr_err valid
//   instr_ready  core -> sequencer    core accepts the instruction
//   instr        sequencer -> core    assembled big-endian instruction
//   instr_pc     sequencer -> core    byte address of instr
//   instr_err    sequencer -> core    fetch PC out of range, instr is 0
// Modports: master = fetch sequencer side, slave = memory/core side.

interface fetch_sequencer_if #(
   parameter int ADDR_W = 8
);
   logic              mem_re;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic [31:0]       instr;
   logic [31:0]       instr_pc;
   logic              instr_err;

   modport master (
      output mem_re, mem_addr, instr_valid, instr, instr_pc, instr_err,
      input  mem_rdata, redirect, redirect_pc, instr_ready
   );

   modport slave (
      input  mem_re, mem_addr, instr_valid, instr, instr_pc, instr_err,
      output mem_rdata, redirect, redirect_pc, instr_ready
   );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// ---------------
// Instruction fetch controller for a byte-wide big-endian program memory.
// Issues four consecutive byte reads per instruction, assembles the bytes
// MSB first into a 32-bit word and presents it to the core over a
// valid/ready handshake. Owns the fetch PC: sequential +4 advance, redirects
// and out-of-range faults.
//
// Parameters
//   MEM_BYTES  program memory size in bytes (valid addresses 0..MEM_BYTES-1)
//   ADDR_W     memory byte-address width
//   RESET_PC   fetch PC loaded on reset
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   bus        fetch_sequencer_if master modport (memory + core ports)
//   dbg_state  current FSM state (0 IDLE, 1 ISSUE, 2 LAST, 3 HOLD)

module fetch_sequencer #(
   parameter int          MEM_BYTES = 256,
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input  logic                clk,
   input  logic                rst,
   fetch_sequencer_if.master   bus,
   output logic [1:0]          dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      LAST  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic [32:0] MAX_ADDR = 33'(MEM_BYTES - 1);

   state_t      state, state_nxt;
   logic [1:0]  cnt, cnt_nxt;
   logic [31:0] pc, pc_nxt;
   // bytes 0..2 of the instruction being assembled; byte 3 goes straight
   // into the output register when entering HOLD
   logic [23:0] asm_q, asm_nxt;
   logic [31:0] instr_q, instr_nxt;
   logic [31:0] ipc_q, ipc_nxt;
   logic        err_q, err_nxt;

   logic [32:0] last_byte;
   logic        range_err;

   // 33-bit so a PC near 2**32 cannot wrap back into range
   assign last_byte = {1'b0, pc} + 33'd3;
   assign range_err = (last_byte > MAX_ADDR);

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pc_nxt      = pc;
      asm_nxt     = asm_q;
      instr_nxt   = instr_q;
      ipc_nxt     = ipc_q;
      err_nxt     = err_q;
      bus.mem_re   = 1'b0;
      bus.mem_addr = '0;

      case (state)
         IDLE: begin
            state_nxt = ISSUE;
            cnt_nxt   = 2'd0;
         end
         ISSUE: begin
            if ((cnt == 2'd0) && range_err) begin
               // no reads; deliver an error instruction next cycle
               state_nxt = HOLD;
               instr_nxt = 32'h0;
               ipc_nxt   = pc;
               err_nxt   = 1'b1;
            end else begin
               bus.mem_re   = 1'b1;
               bus.mem_addr = pc[ADDR_W-1:0] + ADDR_W'(cnt);
               // data returned now belongs to the read of the previous cycle
               case (cnt)
                  2'd1:    asm_nxt[23:16] = bus.mem_rdata;
                  2'd2:    asm_nxt[15:8]  = bus.mem_rdata;
                  2'd3:    asm_nxt[7:0]   = bus.mem_rdata;
                  default: ;
               endcase
               if (cnt == 2'd3) begin
                  state_nxt = LAST;
                  cnt_nxt   = 2'd0;
               end else begin
                  cnt_nxt = cnt + 2'd1;
               end
            end
         end
         LAST: begin
            state_nxt = HOLD;
            instr_nxt = {asm_q, bus.mem_rdata};
            ipc_nxt   = pc;
            err_nxt   = 1'b0;
         end
         HOLD: begin
            if (bus.instr_ready) begin
               pc_nxt    = pc + 32'd4;
               state_nxt = ISSUE;
               cnt_nxt   = 2'd0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // redirect overrides everything; a simultaneous HOLD handshake still
      // counts as a transfer on the bus, but pc takes the redirect target
      if (bus.redirect && (state != IDLE)) begin
         pc_nxt    = bus.redirect_pc;
         state_nxt = ISSUE;
         cnt_nxt   = 2'd0;
         asm_nxt   = asm_q;
         instr_nxt = instr_q;
         ipc_nxt   = ipc_q;
         err_nxt   = err_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 2'd0;
         pc      <= RESET_PC;
         asm_q   <= 24'h0;
         instr_q <= 32'h0;
         ipc_q   <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         pc      <= pc_nxt;
         asm_q   <= asm_nxt;
         instr_q <= instr_nxt;
         ipc_q   <= ipc_nxt;
         err_q   <= err_nxt;
      end
   end

   assign bus.instr_valid = (state == HOLD);
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = ipc_q;
   assign bus.instr_err   = err_q;
   assign dbg_state       = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// ------------------
// Bench for fetch_sequencer: a byte memory model answers reads one cycle
// later, a monitor records read addresses and handshake transfers, and each
// scenario task compares delivered instructions against a word-level model
// of the memory and PC rules.

module tb_fetch_sequencer;

   localparam int          ADDR_W    = 8;
   localparam int          MEM_BYTES = 256;
   localparam logic [31:0] RESET_PC  = 32'h0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] dbg_state;

   fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus();

   fetch_sequencer #(
      .MEM_BYTES(MEM_BYTES),
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // memory model + monitor
   logic [7:0]        mem [0:MEM_BYTES-1];
   logic [ADDR_W-1:0] rd_q[$];
   logic [31:0]       exp_q[$];
   int                xfer_cnt = 0;
   int                n_checks = 0;
   int                n_fail   = 0;

   always @(posedge clk) begin
      if (bus.mem_re === 1'b1) begin
         bus.mem_rdata <= mem[bus.mem_addr];
         rd_q.push_back(bus.mem_addr);
      end else begin
         // garbage when idle, so a capture at the wrong time shows up
         bus.mem_rdata <= 8'($urandom);
      end
      if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1)
         xfer_cnt <= xfer_cnt + 1;
   end

   // reference model
   function automatic bit model_err(input logic [31:0] pc);
      longint last;
      last = longint'(pc) + 3;
      return (last >= longint'(MEM_BYTES));
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] pc);
      int a;
      if (model_err(pc)) return 32'h0;
      a = int'(pc);
      return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
   endfunction

   function automatic logic [31:0] pick_target();
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5)      return 32'($urandom_range(0, 255));
      else if (r == 6) return 32'($urandom_range(248, 255));
      else if (r == 7) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else if (r == 8) return $urandom;
      else             return 32'($urandom_range(0, 63)) * 32'd4;
   endfunction

   // driver tasks
   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_valid(input int limit, output int cycles, output bit timeout);
      cycles  = 0;
      timeout = 1'b1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         cycles++;
         if (bus.instr_valid === 1'b1) begin
            timeout = 1'b0;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.instr_ready = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      rd_q.delete();
   endtask

   // scenarios
   task automatic test_reset();
      rst             = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.instr_ready = 1'b1;
      repeat (2) step();
      #1;
      n_checks++; if (bus.mem_re !== 1'b0) begin n_fail++; $display("FAIL reset_mem_re: got %b want 0", bus.mem_re); end
      n_checks++; if (bus.mem_addr !== 8'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 00", bus.mem_addr); end
      n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
      n_checks++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", bus.instr); end
      n_checks++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h want 0", bus.instr_pc); end
      n_checks++; if (bus.instr_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.instr_err); end
      n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
      @(negedge clk);
      rst = 1'b0;
      rd_q.delete();
      #1;
      n_checks++; if (bus.mem_re !== 1'b0) begin n_fail++; $display("FAIL first_cycle_idle: mem_re got %b want 0", bus.mem_re); end
   endtask

   task automatic test_sequential();
      int cyc;
      bit to;
      wait_valid(20, cyc, to);
      n_checks++; if (to || cyc != 6) begin n_fail++; $display("FAIL seq_latency0: got %0d cycles (timeout %0d) want 6", cyc, to); end
      n_checks++; if (rd_q.size() != 4 || rd_q[0] != 8'd0 || rd_q[1] != 8'd1 || rd_q[2] != 8'd2 || rd_q[3] != 8'd3) begin
         n_fail++; $display("FAIL seq_read_addrs: got %p want 0,1,2,3", rd_q); end
      n_checks++; if (bus.instr !== 32'h1305_0093) begin n_fail++; $display("FAIL seq_instr0: got %h want 13050093", bus.instr); end
      n_checks++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL seq_pc0: got %h want 0", bus.instr_pc); end
      n_checks++; if (bus.instr_err !== 1'b0) begin n_fail++; $display("FAIL seq_err0: got %b want 0", bus.instr_err); end
      rd_q.delete();
      wait_valid(20, cyc, to);
      n_checks++; if (to || cyc != 6) begin n_fail++; $display("FAIL seq_throughput: got %0d cycles (timeout %0d) want 6", cyc, to); end
      n_checks++; if (bus.instr !== 32'h0000_006F) begin n_fail++; $display("FAIL seq_instr1: got %h want 0000006f", bus.instr); end
      n_checks++; if (bus.instr_pc !== 32'h4) begin n_fail++; $display("FAIL seq_pc1: got %h want 4", bus.instr_pc); end
      n_checks++; if (rd_q.size() != 4 || rd_q[0] != 8'd4) begin n_fail++; $display("FAIL seq_read_addrs1: got %p want 4..7", rd_q); end
   endtask

   task automatic test_backpressure();
      logic [31:0] held_instr, held_pc;
      int cyc;
      bit to;
      bus.instr_ready = 1'b0;
      held_instr = bus.instr;
      held_pc    = bus.instr_pc;
      for (int i = 0; i < 10; i++) begin
         step();
         n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.instr_valid); end
         n_checks++; if (bus.instr !== held_instr || bus.instr_pc !== held_pc) begin
            n_fail++; $display("FAIL bp_stable[%0d]: got %h@%h want %h@%h", i, bus.instr, bus.instr_pc, held_instr, held_pc); end
         n_checks++; if (bus.mem_re !== 1'b0) begin n_fail++; $display("FAIL bp_mem_re[%0d]: got %b want 0", i, bus.mem_re); end
      end
      bus.instr_ready = 1'b1;
      rd_q.delete();
      wait_valid(20, cyc, to);
      n_checks++; if (to || cyc != 6) begin n_fail++; $display("FAIL bp_resume_latency: got %0d (timeout %0d) want 6", cyc, to); end
      n_checks++; if (rd_q.size() < 1 || rd_q[0] != 8'd8) begin n_fail++; $display("FAIL bp_resume_addr: got %p want first 08", rd_q); end
      n_checks++; if (bus.instr_pc !== 32'h8 || bus.instr !== model_word(32'h8)) begin
         n_fail++; $display("FAIL bp_resume_instr: got %h@%h want %h@8", bus.instr, bus.instr_pc, model_word(32'h8)); end
   endtask

   task automatic test_redirect_mid();
      int cyc;
      bit to;
      bit found;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.mem_re === 1'b1 && bus.mem_addr === 8'd2) begin
            found = 1'b1;
            break;
         end
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL redir_find_cnt2: got no read of 02 want one"); end
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h20;
      step();
      bus.redirect = 1'b0;
      n_checks++; if (bus.mem_re !== 1'b1 || bus.mem_addr !== 8'h20) begin
         n_fail++; $display("FAIL redir_next_addr: got re=%b addr=%h want re=1 addr=20", bus.mem_re, bus.mem_addr); end
      rd_q.delete();
      wait_valid(20, cyc, to);
      n_checks++; if (to || cyc != 5) begin n_fail++; $display("FAIL redir_latency: got %0d (timeout %0d) want 5", cyc, to); end
      n_checks++; if (bus.instr_pc !== 32'h20) begin n_fail++; $display("FAIL redir_pc: got %h want 20", bus.instr_pc); end
      n_checks++; if (bus.instr !== 32'hA1B2_C3D4 || bus.instr_err !== 1'b0) begin
         n_fail++; $display("FAIL redir_instr: got %h err %b want a1b2c3d4 err 0", bus.instr, bus.instr_err); end
   endtask

   task automatic test_redirect_handshake();
      int cyc, x0;
      bit to;
      x0 = xfer_cnt;
      bus.instr_ready = 1'b1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h40;
      step();
      bus.redirect = 1'b0;
      n_checks++; if (xfer_cnt - x0 != 1) begin n_fail++; $display("FAIL rh_transfer: got %0d want 1", xfer_cnt - x0); end
      n_checks++; if (bus.mem_re !== 1'b1 || bus.mem_addr !== 8'h40) begin
         n_fail++; $display("FAIL rh_addr: got re=%b addr=%h want re=1 addr=40", bus.mem_re, bus.mem_addr); end
      rd_q.delete();
      wait_valid(20, cyc, to);
      n_checks++; if (to || bus.instr_pc !== 32'h40) begin n_fail++; $display("FAIL rh_next_pc: got %h (timeout %0d) want 40", bus.instr_pc, to); end
      n_checks++; if (bus.instr !== model_word(32'h40)) begin n_fail++; $display("FAIL rh_instr: got %h want %h", bus.instr, model_word(32'h40)); end
      n_checks++; if (xfer_cnt - x0 != 1) begin n_fail++; $display("FAIL rh_single_transfer: got %0d want 1", xfer_cnt - x0); end
   endtask

   task automatic test_out_of_range();
      int cyc;
      bit to;
      bus.instr_ready = 1'b0;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'hFE;
      step();
      bus.redirect = 1'b0;
      n_checks++; if (bus.mem_re !== 1'b0 || dbg_state !== 2'd1) begin
         n_fail++; $display("FAIL oor_issue: got re=%b state=%0d want re=0 state=1", bus.mem_re, dbg_state); end
      rd_q.delete();
      wait_valid(10, cyc, to);
      n_checks++; if (to || cyc != 1) begin n_fail++; $display("FAIL oor_latency: got %0d (timeout %0d) want 1", cyc, to); end
      n_checks++; if (bus.instr !== 32'h0 || bus.instr_err !== 1'b1 || bus.instr_pc !== 32'hFE) begin
         n_fail++; $display("FAIL oor_fe: got %h err %b pc %h want 0 err 1 pc fe", bus.instr, bus.instr_err, bus.instr_pc); end
      bus.instr_ready = 1'b1;
      wait_valid(10, cyc, to);
      n_checks++; if (to || cyc != 2) begin n_fail++; $display("FAIL oor_adv_latency: got %0d (timeout %0d) want 2", cyc, to); end
      n_checks++; if (bus.instr !== 32'h0 || bus.instr_err !== 1'b1 || bus.instr_pc !== 32'h102) begin
         n_fail++; $display("FAIL oor_102: got %h err %b pc %h want 0 err 1 pc 102", bus.instr, bus.instr_err, bus.instr_pc); end
      n_checks++; if (rd_q.size() != 0) begin n_fail++; $display("FAIL oor_no_reads: got %0d reads want 0", rd_q.size()); end
   endtask

   task automatic test_random();
      logic [31:0] cur, nxt, e, t2, held_instr, held_pc;
      int cyc, stall, choice, k;
      bit to, rd_ok;
      cur = 32'h102;
      for (int it = 0; it < 40; it++) begin
         bus.instr_ready = 1'b0;
         held_instr = bus.instr;
         held_pc    = bus.instr_pc;
         stall = $urandom_range(0, 3);
         for (int s = 0; s < stall; s++) begin
            step();
            n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== held_instr || bus.instr_pc !== held_pc) begin
               n_fail++; $display("FAIL rnd_stall[%0d]: got v=%b %h@%h want v=1 %h@%h", it, bus.instr_valid, bus.instr, bus.instr_pc, held_instr, held_pc); end
         end
         choice = $urandom_range(0, 3);
         if (choice == 2) begin
            nxt = pick_target();
            bus.redirect    = 1'b1;
            bus.redirect_pc = nxt;
            bus.instr_ready = 1'($urandom_range(0, 1));
         end else begin
            nxt = cur + 32'd4;
            bus.instr_ready = 1'b1;
         end
         step();
         bus.redirect    = 1'b0;
         bus.instr_ready = 1'b0;
         rd_q.delete();
         if (choice == 3) begin
            k = $urandom_range(0, 2);
            repeat (k) step();
            if (bus.instr_valid !== 1'b1) begin
               t2 = pick_target();
               bus.redirect    = 1'b1;
               bus.redirect_pc = t2;
               step();
               bus.redirect = 1'b0;
               rd_q.delete();
               nxt = t2;
            end
         end
         exp_q.push_back(nxt);
         wait_valid(20, cyc, to);
         e = exp_q.pop_front();
         n_checks++; if (to) begin n_fail++; $display("FAIL rnd_timeout[%0d]: got no instr_valid want one", it); end
         n_checks++; if (bus.instr_pc !== e) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", it, bus.instr_pc, e); end
         n_checks++; if (bus.instr !== model_word(e) || bus.instr_err !== model_err(e)) begin
            n_fail++; $display("FAIL rnd_instr[%0d]: got %h err %b want %h err %b", it, bus.instr, bus.instr_err, model_word(e), model_err(e)); end
         rd_ok = 1'b1;
         if (model_err(e)) begin
            if (rd_q.size() != 0) rd_ok = 1'b0;
         end else begin
            if (rd_q.size() != 4) rd_ok = 1'b0;
            else for (int i = 0; i < 4; i++) if (rd_q[i] != 8'(e + 32'(i))) rd_ok = 1'b0;
         end
         n_checks++; if (!rd_ok) begin n_fail++; $display("FAIL rnd_reads[%0d]: got %p want 4 reads from %h (or none if err)", it, rd_q, e); end
         cur = e;
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      bit to;
      bus.instr_ready = 1'b0;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h10;
      step();
      bus.redirect = 1'b0;
      step();
      n_checks++; if (bus.mem_re !== 1'b1 || bus.mem_addr !== 8'h11) begin
         n_fail++; $display("FAIL rm_cnt1: got re=%b addr=%h want re=1 addr=11", bus.mem_re, bus.mem_addr); end
      rst = 1'b1;
      #1;
      n_checks++; if (bus.mem_re !== 1'b0 || bus.mem_addr !== 8'h0 || bus.instr_valid !== 1'b0) begin
         n_fail++; $display("FAIL rm_async_bus: got re=%b addr=%h v=%b want 0 0 0", bus.mem_re, bus.mem_addr, bus.instr_valid); end
      n_checks++; if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0 || bus.instr_err !== 1'b0) begin
         n_fail++; $display("FAIL rm_async_instr: got %h@%h err %b want 0@0 err 0", bus.instr, bus.instr_pc, bus.instr_err); end
      step();
      rst = 1'b0;
      bus.instr_ready = 1'b1;
      rd_q.delete();
      wait_valid(20, cyc, to);
      n_checks++; if (to || cyc != 6) begin n_fail++; $display("FAIL rm_restart_latency: got %0d (timeout %0d) want 6", cyc, to); end
      n_checks++; if (bus.instr_pc !== RESET_PC || bus.instr !== model_word(RESET_PC)) begin
         n_fail++; $display("FAIL rm_restart_instr: got %h@%h want %h@%h", bus.instr, bus.instr_pc, model_word(RESET_PC), RESET_PC); end
      n_checks++; if (rd_q.size() != 4 || rd_q[0] != RESET_PC[7:0]) begin n_fail++; $display("FAIL rm_restart_reads: got %p want 00..03", rd_q); end
   endtask

   initial begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h93;
      mem[4] = 8'h00; mem[5] = 8'h00; mem[6] = 8'h00; mem[7] = 8'h6F;
      mem[32] = 8'hA1; mem[33] = 8'hB2; mem[34] = 8'hC3; mem[35] = 8'hD4;

      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_mid();
      test_redirect_handshake();
      test_out_of_range();
      test_random();
      test_reset_mid();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch controller that sequences the byte-wide, big-endian program memory. It generates four consecutive byte reads per instruction and assembles the returned bytes into a 32-bit instruction, most significant byte first. It presents the instruction to the core over a valid/ready handshake. It sits between the core's PC/branch logic and the program memory, and owns the fetch PC, sequential increment, redirects and range faults.

## Interface

- `MEM_BYTES`, default 256: program memory size in bytes; valid byte addresses are 0..MEM_BYTES-1.
- `ADDR_W`, default 8: memory byte-address width; must satisfy 2**ADDR_W >= MEM_BYTES.
- `RESET_PC`, default 32'h0: fetch PC loaded on reset.

- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_re` out 1: byte read strobe.
- `mem_addr` out ADDR_W: byte address for `mem_re`, equal to (pc+k)[ADDR_W-1:0].
- `mem_rdata` in 8: read data, valid exactly one cycle after the `mem_re` cycle.
- `redirect` in 1: load a new fetch PC and abandon the current fetch.
- `redirect_pc` in 32: target byte address, sampled when `redirect`=1; no alignment required.
- `instr_valid` out 1: `instr`, `instr_pc` and `instr_err` are valid.
- `instr_ready` in 1: the core accepts the instruction.
- `instr` out 32: assembled instruction; byte at pc goes to [31:24], pc+3 goes to [7:0].
- `instr_pc` out 32: byte address of `instr`.
- `instr_err` out 1: the fetch PC was out of range and `instr` is 32'h0.

## Operation

- **State machine.**
  - IDLE: entered on reset; unconditionally goes to ISSUE on the next edge.
  - ISSUE: `issue_cnt` runs 0..3.
  - LAST: one cycle.
  - HOLD: instruction presented to the core.
- **ISSUE, cnt=k.**
  - Drive `mem_re`=1 and `mem_addr`=pc+k.
  - For k>0, capture `mem_rdata` as byte k-1.
  - k=3 goes to LAST.
- **LAST.** `mem_re`=0; capture byte 3; go to HOLD.
- **HOLD.**
  - `instr_valid`=1.
  - On `instr_valid & instr_ready` at an edge: pc <= pc+4 (32-bit wrap), then go to ISSUE cnt 0.
  - Otherwise stay; outputs remain stable.
- **Range check** on ISSUE cnt 0, computed in 33 bits:
  - Condition: pc+3 > MEM_BYTES-1.
  - Effect: `mem_re`=0, then go directly to HOLD with `instr`=0, `instr_err`=1, `instr_pc`=pc.
  - Acceptance of an error instruction advances pc by 4 as normal.
- **Redirect** (any state except IDLE) has priority over all other transitions.
  - Updates: pc <= redirect_pc, state <= ISSUE cnt 0, `instr_valid` <= 0.
  - Read data in flight from the redirect cycle is not captured; cnt 0 captures nothing.
- **Redirect and handshake in the same HOLD cycle.** The transfer counts as accepted, and the next PC is redirect_pc, not pc+4.
- `instr`, `instr_pc` and `instr_err` only change on entry to HOLD. The assembly register may change outside HOLD; `instr` is taken from a separate output register.

## Timing

- **Reset values:**
  - `mem_re`=0, `mem_addr`=0
  - `instr_valid`=0, `instr`=0, `instr_pc`=0, `instr_err`=0
  - pc=RESET_PC, state=IDLE
- **First cycle after reset release:** IDLE, so `mem_re`=0. The first read is issued in the following cycle.
- **Latency from the ISSUE cnt 0 cycle (T0):**
  - Reads are issued in T0..T3.
  - Data is captured at the ends of T1..T4.
  - `instr_valid` rises in T5.
  - Zero-wait throughput is one instruction per 6 cycles; the next T0 is the cycle after acceptance.
- **Out-of-range fetch:** `instr_valid` rises in T1.
- **Redirect asserted in cycle R:** a new ISSUE cnt 0 occurs in R+1 with `mem_addr`=redirect_pc[ADDR_W-1:0].
- **`rst` asserted mid-fetch:** all outputs clear immediately (asynchronously), the partially assembled instruction is discarded, and the sequence restarts from RESET_PC.
- `instr_ready` may be held high permanently. Deasserting `instr_ready` while `instr_valid`=1 does not drop `instr_valid`.

## Test plan

1. **Reset then sequential fetch.** Memory[0..7]=13,05,00,93,00,00,00,6F and `instr_ready`=1.
   - `mem_re` is 0 in the cycle after reset.
   - Reads go to addresses 0,1,2,3.
   - `instr`=32'h13050093 with `instr_pc`=0 at T5.
   - Then `instr`=32'h0000006F with `instr_pc`=4.
2. **Backpressure.** Hold `instr_ready`=0 for 10 cycles.
   - `instr_valid` and `instr` stay stable and `mem_re` stays 0.
   - After `instr_ready` rises, the next reads start at pc+4.
3. **Redirect mid-fetch.** Pulse `redirect` with `redirect_pc`=32'h20 during ISSUE cnt 2 of the fetch at 0.
   - The next cycle reads address 0x20.
   - The delivered instruction has `instr_pc`=0x20 and no bytes from address 0/1.
4. **Redirect together with handshake in HOLD.** Target 32'h40.
   - The consumer records one transfer.
   - The next `instr_pc` is 0x40, not pc+4.
5. **Out of range.** With MEM_BYTES=256, redirect to 32'hFE.
   - No `mem_re` pulses occur.
   - `instr_valid` is seen one cycle after ISSUE with `instr`=0 and `instr_err`=1.
   - Acceptance advances to 0x102, which also errors.
6. **Reset mid-fetch.** Assert `rst` during ISSUE cnt 1.
   - Outputs are 0 in that cycle, before the next edge.
   - After release, fetch restarts at RESET_PC.
